dense_mac_scheduler: RTL and testbench

DENSE_MAC_SCHEDULER -- requirements
Module: dense_mac_scheduler

---
 rtl/dense_mac_scheduler_if.sv | 25 ++
 rtl/dense_mac_scheduler.sv | 121 ++++++++++++
 tb/tb_dense_mac_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dense_mac_scheduler_if.sv
// Handshake and data bundle for dense_mac_scheduler: one input-vector channel
// and one result-vector channel, plus a busy indicator.
interface dense_mac_scheduler_if #(
  parameter int WIDTH       = 8,
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] input_data [0:INPUT_SIZE-1];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] output_data [0:OUTPUT_SIZE-1];
  logic                    busy;

  modport master (
    output in_valid, input_data, out_ready,
    input  in_ready, out_valid, output_data, busy
  );

  modport slave (
    input  in_valid, input_data, out_ready,
    output in_ready, out_valid, output_data, busy
  );
endinterface

// File: rtl/dense_mac_scheduler.sv
// Fully connected layer y = relu(sat(W^T x + b)) evaluated with a single
// time-shared multiplier, one product per MAC cycle, one WRITE per output.
module dense_mac_scheduler #(
  parameter int WIDTH       = 8,
  parameter int NFRAC       = 0,
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 5,
  parameter logic signed [WIDTH-1:0] WEIGHTS [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1] = '{
    '{1, 0, 0, 0, 0},
    '{0, 1, 0, 0, 0},
    '{0, 0, 1, 0, 0},
    '{0, 0, 0, 1, 0},
    '{0, 0, 0, 0, 1},
    '{0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0}
  },
  parameter logic signed [WIDTH-1:0] BIAS [0:OUTPUT_SIZE-1] = '{default: '0},
  parameter int RELU = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  dense_mac_scheduler_if.slave  io
);

  localparam int ACC_W = 2*WIDTH + $clog2(INPUT_SIZE) + 1;
  localparam int IW    = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
  localparam int JW    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUTPUT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] MAXV = $signed({{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] MINV = $signed({{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           i_q;
  logic [JW-1:0]           j_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WIDTH-1:0] x_q   [0:INPUT_SIZE-1];
  logic signed [WIDTH-1:0] res_q [0:OUTPUT_SIZE-1];
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0] wr_val;

  // Bias is pre-scaled into the accumulator's fixed-point frame.
  function automatic logic signed [ACC_W-1:0] bias_acc(input logic [JW-1:0] j);
    return ACC_W'(BIAS[j]) <<< NFRAC;
  endfunction

  // Arithmetic shift floors toward -inf; ReLU then clamp to the output range.
  function automatic logic signed [WIDTH-1:0] sat_relu(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> NFRAC;
    if (RELU != 0 && s < 0) return '0;
    if (s > MAXV) return MAXV[WIDTH-1:0];
    if (s < MINV) return MINV[WIDTH-1:0];
    return s[WIDTH-1:0];
  endfunction

  assign prod   = (2*WIDTH)'(x_q[i_q]) * (2*WIDTH)'(WEIGHTS[i_q][j_q]);
  assign wr_val = sat_relu(acc_q);

  always_comb begin
    state_d      = state_q;
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    io.busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    if (io.in_valid) state_d = MAC;
      MAC:     if (i_q == I_LAST) state_d = WRITE;
      WRITE:   state_d = (j_q == J_LAST) ? DONE : MAC;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        res_q[k]          <= '0;
        io.output_data[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (io.in_valid) begin
          i_q   <= '0;
          j_q   <= '0;
          acc_q <= bias_acc('0);
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          if (i_q != I_LAST) i_q <= i_q + 1'b1;
        end
        WRITE: begin
          res_q[j_q] <= wr_val;
          // The last WRITE publishes the whole vector, including the value just formed.
          if (j_q == J_LAST) begin
            for (int k = 0; k < OUTPUT_SIZE; k++)
              io.output_data[k] <= (JW'(k) == j_q) ? wr_val : res_q[k];
          end else begin
            j_q   <= j_q + 1'b1;
            i_q   <= '0;
            acc_q <= bias_acc(j_q + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture carries no reset; it is only read after an accept.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && io.in_valid) x_q <= io.input_data;
  end

endmodule

// File: tb/tb_dense_mac_scheduler.sv
// Directed bench for dense_mac_scheduler: default identity layer, a RELU=0
// variant, an all-ones saturating layer and an NFRAC=4 fixed-point layer.
module tb_dense_mac_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dense_mac_scheduler_if i0 ();
  dense_mac_scheduler_if i1 ();
  dense_mac_scheduler_if i2 ();
  dense_mac_scheduler_if i3 ();

  dense_mac_scheduler u0 (.clk(clk), .reset(reset), .io(i0));
  dense_mac_scheduler #(.RELU(0)) u1 (.clk(clk), .reset(reset), .io(i1));
  dense_mac_scheduler #(.RELU(0), .WEIGHTS('{8{'{5{8'sd1}}}})) u2 (.clk(clk), .reset(reset), .io(i2));
  dense_mac_scheduler #(
    .NFRAC(4),
    .WEIGHTS('{'{8'sh10, 0, 0, 0, 0}, '{5{8'sd0}}, '{5{8'sd0}}, '{5{8'sd0}},
               '{5{8'sd0}}, '{5{8'sd0}}, '{5{8'sd0}}, '{5{8'sd0}}}),
    .BIAS('{8'sh08, 0, 0, 0, 0})
  ) u3 (.clk(clk), .reset(reset), .io(i3));

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  int acc_edge = 0;
  int prev_acc = 0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (i0.in_valid && i0.in_ready) begin
      acc_edge <= edge_n + 1;
      prev_acc <= acc_edge;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int e [0:4]);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(i0.output_data[k]), e[k]);
  endtask

  task automatic send(input logic signed [7:0] v [0:7]);
    i0.input_data = v;
    i0.in_valid = 1'b1;
    @(negedge clk);
    i0.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (i0.out_valid === 1'b1) begin
        lat = edge_n - acc_edge;
        break;
      end
    end
    check(tag, lat, 45);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int saved;
    int seen;
    i0.in_valid = 0; i0.out_ready = 0; i0.input_data = '{default: 0};
    i1.in_valid = 0; i1.out_ready = 0; i1.input_data = '{default: 0};
    i2.in_valid = 0; i2.out_ready = 0; i2.input_data = '{default: 0};
    i3.in_valid = 0; i3.out_ready = 0; i3.input_data = '{default: 0};
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(i0.in_ready), 1);
    check("rst_out_valid", 32'(i0.out_valid), 0);
    check("rst_busy", 32'(i0.busy), 0);
    check_out("rst_out", '{0, 0, 0, 0, 0});
    reset = 1'b0;
    @(negedge clk);

    // Basic result, latency, post-capture input change, held output.
    send('{3, -4, 5, 7, -2, 9, 9, 9});
    repeat (3) @(negedge clk);
    i0.input_data = '{8{8'sd55}};
    wait_out("lat_a");
    check_out("res_a", '{3, 0, 5, 7, 0});
    bad = 0;
    saved = acc_edge;
    for (int c = 0; c < 20; c++) begin
      i0.in_valid = c[0];
      @(negedge clk);
      if (i0.out_valid !== 1'b1 || i0.busy !== 1'b1 || i0.in_ready !== 1'b0) bad++;
      if (i0.output_data[0] !== 3 || i0.output_data[1] !== 0 || i0.output_data[2] !== 5 ||
          i0.output_data[3] !== 7 || i0.output_data[4] !== 0) bad++;
    end
    check("hold_cycles", bad, 0);
    check("no_accept_in_done", acc_edge, saved);
    i0.in_valid = 1'b0;
    i0.out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(i0.out_valid), 0);
    check("release_in_ready", 32'(i0.in_ready), 1);
    check("release_busy", 32'(i0.busy), 0);
    check_out("after_done", '{3, 0, 5, 7, 0});

    // Reset mid-computation.
    send('{-1, 2, -3, 4, -5, 0, 0, 0});
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", 32'(i0.in_ready), 1);
    check("midrst_out_valid", 32'(i0.out_valid), 0);
    check("midrst_busy", 32'(i0.busy), 0);
    check_out("midrst_out", '{0, 0, 0, 0, 0});
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i0.out_valid !== 1'b0) bad++;
    end
    check("no_partial", bad, 0);
    send('{10, 20, 30, 40, 50, 1, 2, 3});
    wait_out("lat_c");
    check_out("res_c", '{10, 20, 30, 40, 50});

    // Continuous in_valid: back-to-back accepts.
    i0.input_data = '{-1, 2, -3, 4, -5, 0, 0, 0};
    i0.in_valid = 1'b1;
    wait_out("lat_b");
    check_out("res_b", '{0, 2, 0, 4, 0});
    i0.input_data = '{3, -4, 5, 7, -2, 9, 9, 9};
    wait_out("lat_a2");
    check("spacing1", acc_edge - prev_acc, 47);
    check_out("res_a2", '{3, 0, 5, 7, 0});
    i0.input_data = '{10, 20, 30, 40, 50, 1, 2, 3};
    wait_out("lat_c2");
    check("spacing2", acc_edge - prev_acc, 47);
    check_out("res_c2", '{10, 20, 30, 40, 50});
    i0.in_valid = 1'b0;
    i0.out_ready = 1'b0;

    // Parameter variants.
    i1.input_data = '{3, -4, 5, 7, -2, 9, 9, 9};
    i2.input_data = '{8{8'sd100}};
    i3.input_data = '{8'sh18, 0, 0, 0, 0, 0, 0, 0};
    i1.in_valid = 1; i2.in_valid = 1; i3.in_valid = 1;
    @(negedge clk);
    i1.in_valid = 0; i2.in_valid = 0; i3.in_valid = 0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i1.out_valid === 1'b1) begin seen = 1; break; end
    end
    check("aux_done", seen, 1);
    check("aux_nfrac_valid", 32'(i3.out_valid), 1);
    check("norelu[0]", 32'(i1.output_data[0]), 3);
    check("norelu[1]", 32'(i1.output_data[1]), -4);
    check("norelu[2]", 32'(i1.output_data[2]), 5);
    check("norelu[3]", 32'(i1.output_data[3]), 7);
    check("norelu[4]", 32'(i1.output_data[4]), -2);
    for (int k = 0; k < 5; k++)
      check($sformatf("sat_pos[%0d]", k), 32'(i2.output_data[k]), 127);
    check("nfrac[0]", 32'(i3.output_data[0]), 32'h20);
    check("nfrac[1]", 32'(i3.output_data[1]), 0);

    i2.out_ready = 1'b1;
    @(negedge clk);
    i2.out_ready = 1'b0;
    i2.input_data = '{8{-8'sd100}};
    i2.in_valid = 1'b1;
    @(negedge clk);
    i2.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i2.out_valid === 1'b1) begin seen = 1; break; end
    end
    check("sat_neg_done", seen, 1);
    for (int k = 0; k < 5; k++)
      check($sformatf("sat_neg[%0d]", k), 32'(i2.output_data[k]), -128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
